// File: rtl/instr_fetch_if.sv
// instr_fetch_if
// Bundles every non-clock, non-reset signal of the fetch stage. The signals
// cover the instruction memory, the IF/ID handshake with decode, redirects
// and halt.
//   master : the fetch stage. It drives ProgCounter, Instr, InstrPC,
//            InstrValid and Halted.
//   slave  : the environment (memory, decode, execute). It drives IMemData,
//            InstrReady, BranchEn/Base/Offset, JumpEn/Target and Halt.
interface instr_fetch_if;
  logic [9:0]  ProgCounter;
  logic [31:0] IMemData;
  logic [31:0] Instr;
  logic [9:0]  InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        BranchEn;
  logic [9:0]  BranchBase;
  logic [15:0] BranchOffset;
  logic        JumpEn;
  logic [25:0] JumpTarget;
  logic        Halt;
  logic        Halted;

  modport master (
    output ProgCounter, Instr, InstrPC, InstrValid, Halted,
    input  IMemData, InstrReady, BranchEn, BranchBase, BranchOffset,
           JumpEn, JumpTarget, Halt
  );

  modport slave (
    input  ProgCounter, Instr, InstrPC, InstrValid, Halted,
    output IMemData, InstrReady, BranchEn, BranchBase, BranchOffset,
           JumpEn, JumpTarget, Halt
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch
// Fetch stage of the Turboencabulator core. It owns the program counter and
// addresses instruction memory with it. The combinational read data is
// captured into the IF/ID register, which is offered to decode under a
// valid/ready handshake. Branch and jump redirects flush the IF/ID register.
// A sticky halt freezes the stage until reset.
// Ports:
//   clk    : core clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : instr_fetch_if master modport (memory, IF/ID, redirect, halt)
// Parameter:
//   RESET_PC : first byte address fetched after reset (word aligned)
module instr_fetch #(
  parameter logic [9:0] RESET_PC = 10'h000
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e      state_q, state_d;
  logic [9:0]  pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [9:0]  instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;

  logic        load;
  logic [9:0]  jump_target;
  logic [17:0] branch_sum;
  logic        unused_bits;

  assign load = !valid_q || bus.InstrReady;

  // The jump target is a word index. Only the low 8 bits fit in a 10-bit
  // byte address.
  assign jump_target = {bus.JumpTarget[7:0], 2'b00};

  // Shifting the 16-bit word offset left by 2 gives an 18-bit signed value.
  // Its sign extension is the concatenation itself at 18 bits. Only [9:0]
  // survives the mod-1024 wrap.
  assign branch_sum = {8'b0, bus.BranchBase} + 18'd4 + {bus.BranchOffset, 2'b00};

  assign unused_bits = ^{bus.JumpTarget[25:8], branch_sum[17:10]};

  // Next-state logic. Within RUN, the priority is halt, jump, branch, load,
  // then stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    case (state_q)
      RUN: begin
        if (bus.Halt) begin
          state_d = HALTED;
          valid_d = 1'b0;
        end else if (bus.JumpEn) begin
          pc_d    = jump_target;
          valid_d = 1'b0;
        end else if (bus.BranchEn) begin
          pc_d    = branch_sum[9:0];
          valid_d = 1'b0;
        end else if (load) begin
          instr_d    = bus.IMemData;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + 10'd4;
        end
      end
      HALTED: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = HALTED;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= 10'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.ProgCounter = pc_q;
  assign bus.Instr       = instr_q;
  assign bus.InstrPC     = instr_pc_q;
  assign bus.InstrValid  = valid_q;
  assign bus.Halted      = (state_q == HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
// Directed bench for instr_fetch. The main instance uses RESET_PC = 0.
// A second instance uses RESET_PC = 0x3F8 and covers PC wrap. Both model
// instruction memory so that the word at byte address 4*i holds i.
module tb_instr_fetch;

  logic clk;
  logic rst_n;
  logic rst2_n;
  int   total;
  int   bad;

  instr_fetch_if bus();
  instr_fetch_if bus2();

  instr_fetch #(.RESET_PC(10'h000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  instr_fetch #(.RESET_PC(10'h3F8)) dut_wrap (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  // Word i holds the value i.
  assign bus.IMemData  = {24'h0, bus.ProgCounter[9:2]};
  assign bus2.IMemData = {24'h0, bus2.ProgCounter[9:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.InstrReady   = 1'b1;
    bus.BranchEn     = 1'b0;
    bus.BranchBase   = 10'h0;
    bus.BranchOffset = 16'h0;
    bus.JumpEn       = 1'b0;
    bus.JumpTarget   = 26'h0;
    bus.Halt         = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #2;
    total++;
    if ({bus.ProgCounter, bus.Instr, bus.InstrPC, bus.InstrValid, bus.Halted} !==
        {10'h000, 32'h0, 10'h000, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset pc=%h instr=%h ipc=%h v=%b h=%b required 000 0 000 0 0",
               bus.ProgCounter, bus.Instr, bus.InstrPC, bus.InstrValid, bus.Halted);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] exp_instr [3] = '{32'd0, 32'd1, 32'd2};
    logic [9:0]  exp_ipc   [3] = '{10'h000, 10'h004, 10'h008};
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus.Instr, bus.InstrPC, bus.InstrValid, bus.ProgCounter} !==
          {exp_instr[i], exp_ipc[i], 1'b1, exp_ipc[i] + 10'd4}) begin
        bad++;
        $display("[TB] FAIL stream%0d instr=%h ipc=%h v=%b pc=%h required %h %h 1 %h",
                 i, bus.Instr, bus.InstrPC, bus.InstrValid, bus.ProgCounter,
                 exp_instr[i], exp_ipc[i], exp_ipc[i] + 10'd4);
      end
    end
  endtask

  task automatic test_stall();
    bus.InstrReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus.Instr, bus.InstrPC, bus.InstrValid, bus.ProgCounter} !==
          {32'd2, 10'h008, 1'b1, 10'h00C}) begin
        bad++;
        $display("[TB] FAIL stall%0d instr=%h ipc=%h v=%b pc=%h required 2 008 1 00c",
                 i, bus.Instr, bus.InstrPC, bus.InstrValid, bus.ProgCounter);
      end
    end
    bus.InstrReady = 1'b1;
    tick();
    total++;
    if ({bus.Instr, bus.InstrPC, bus.InstrValid, bus.ProgCounter} !==
        {32'd3, 10'h00C, 1'b1, 10'h010}) begin
      bad++;
      $display("[TB] FAIL stall_release instr=%h ipc=%h v=%b pc=%h required 3 00c 1 010",
               bus.Instr, bus.InstrPC, bus.InstrValid, bus.ProgCounter);
    end
  endtask

  task automatic test_branch();
    // 0x010 + 4 - 16 = 0x004
    bus.BranchEn = 1'b1; bus.BranchBase = 10'h010; bus.BranchOffset = 16'hFFFC;
    tick();
    bus.BranchEn = 1'b0;
    total++;
    if ({bus.InstrValid, bus.ProgCounter} !== {1'b0, 10'h004}) begin
      bad++;
      $display("[TB] FAIL branch_back_bubble v=%b pc=%h required 0 004",
               bus.InstrValid, bus.ProgCounter);
    end
    tick();
    total++;
    if ({bus.Instr, bus.InstrPC, bus.InstrValid} !== {32'd1, 10'h004, 1'b1}) begin
      bad++;
      $display("[TB] FAIL branch_back_target instr=%h ipc=%h v=%b required 1 004 1",
               bus.Instr, bus.InstrPC, bus.InstrValid);
    end
    // 0x3F8 + 4 + 8 = 0x404 -> 0x004
    bus.BranchEn = 1'b1; bus.BranchBase = 10'h3F8; bus.BranchOffset = 16'h0002;
    tick();
    bus.BranchEn = 1'b0;
    total++;
    if ({bus.InstrValid, bus.ProgCounter} !== {1'b0, 10'h004}) begin
      bad++;
      $display("[TB] FAIL branch_wrap_bubble v=%b pc=%h required 0 004",
               bus.InstrValid, bus.ProgCounter);
    end
    tick();
    total++;
    if ({bus.Instr, bus.InstrPC, bus.InstrValid} !== {32'd1, 10'h004, 1'b1}) begin
      bad++;
      $display("[TB] FAIL branch_wrap_target instr=%h ipc=%h v=%b required 1 004 1",
               bus.Instr, bus.InstrPC, bus.InstrValid);
    end
    // Branch while stalled: 0x020 + 4 + 12 = 0x030, and the stalled word is dropped.
    bus.InstrReady = 1'b0;
    bus.BranchEn = 1'b1; bus.BranchBase = 10'h020; bus.BranchOffset = 16'h0003;
    tick();
    bus.BranchEn = 1'b0;
    total++;
    if ({bus.InstrValid, bus.ProgCounter} !== {1'b0, 10'h030}) begin
      bad++;
      $display("[TB] FAIL branch_stall_flush v=%b pc=%h required 0 030",
               bus.InstrValid, bus.ProgCounter);
    end
    bus.InstrReady = 1'b1;
    tick();
    total++;
    if ({bus.Instr, bus.InstrPC, bus.InstrValid} !== {32'h0C, 10'h030, 1'b1}) begin
      bad++;
      $display("[TB] FAIL branch_stall_target instr=%h ipc=%h v=%b required c 030 1",
               bus.Instr, bus.InstrPC, bus.InstrValid);
    end
  endtask

  task automatic test_jump_priority();
    bus.JumpEn = 1'b1; bus.JumpTarget = 26'h3FFFF40;
    bus.BranchEn = 1'b1; bus.BranchBase = 10'h010; bus.BranchOffset = 16'h0000;
    tick();
    bus.JumpEn = 1'b0; bus.BranchEn = 1'b0;
    total++;
    if ({bus.InstrValid, bus.ProgCounter} !== {1'b0, 10'h100}) begin
      bad++;
      $display("[TB] FAIL jump_prio_bubble v=%b pc=%h required 0 100",
               bus.InstrValid, bus.ProgCounter);
    end
    tick();
    total++;
    if ({bus.Instr, bus.InstrPC, bus.InstrValid, bus.ProgCounter} !==
        {32'h40, 10'h100, 1'b1, 10'h104}) begin
      bad++;
      $display("[TB] FAIL jump_prio_target instr=%h ipc=%h v=%b pc=%h required 40 100 1 104",
               bus.Instr, bus.InstrPC, bus.InstrValid, bus.ProgCounter);
    end
  endtask

  task automatic test_halt_reset();
    bus.Halt = 1'b1;
    bus.BranchEn = 1'b1; bus.BranchBase = 10'h010; bus.BranchOffset = 16'h0005;
    tick();
    bus.Halt = 1'b0; bus.BranchEn = 1'b0;
    total++;
    if ({bus.Halted, bus.InstrValid, bus.ProgCounter, bus.Instr, bus.InstrPC} !==
        {1'b1, 1'b0, 10'h104, 32'h40, 10'h100}) begin
      bad++;
      $display("[TB] FAIL halt_enter h=%b v=%b pc=%h instr=%h ipc=%h required 1 0 104 40 100",
               bus.Halted, bus.InstrValid, bus.ProgCounter, bus.Instr, bus.InstrPC);
    end
    for (int i = 0; i < 5; i++) begin
      bus.JumpEn = 1'b1; bus.JumpTarget = 26'h20 + 26'(i);
      tick();
      total++;
      if ({bus.Halted, bus.InstrValid, bus.ProgCounter} !== {1'b1, 1'b0, 10'h104}) begin
        bad++;
        $display("[TB] FAIL halt_hold%0d h=%b v=%b pc=%h required 1 0 104",
                 i, bus.Halted, bus.InstrValid, bus.ProgCounter);
      end
    end
    bus.JumpEn = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.Halted, bus.InstrValid, bus.ProgCounter, bus.Instr, bus.InstrPC} !==
        {1'b0, 1'b0, 10'h000, 32'h0, 10'h000}) begin
      bad++;
      $display("[TB] FAIL async_reset h=%b v=%b pc=%h instr=%h ipc=%h required 0 0 000 0 000",
               bus.Halted, bus.InstrValid, bus.ProgCounter, bus.Instr, bus.InstrPC);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({bus.Instr, bus.InstrPC, bus.InstrValid, bus.Halted} !==
        {32'd0, 10'h000, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL restart instr=%h ipc=%h v=%b h=%b required 0 000 1 0",
               bus.Instr, bus.InstrPC, bus.InstrValid, bus.Halted);
    end
  endtask

  task automatic test_wrap();
    logic [9:0]  exp_ipc   [3] = '{10'h3F8, 10'h3FC, 10'h000};
    logic [31:0] exp_instr [3] = '{32'hFE, 32'hFF, 32'h00};
    rst2_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus2.Instr, bus2.InstrPC, bus2.InstrValid} !== {exp_instr[i], exp_ipc[i], 1'b1}) begin
        bad++;
        $display("[TB] FAIL wrap%0d instr=%h ipc=%h v=%b required %h %h 1",
                 i, bus2.Instr, bus2.InstrPC, bus2.InstrValid, exp_instr[i], exp_ipc[i]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst2_n = 1'b0;
    bus2.InstrReady   = 1'b1;
    bus2.BranchEn     = 1'b0;
    bus2.BranchBase   = 10'h0;
    bus2.BranchOffset = 16'h0;
    bus2.JumpEn       = 1'b0;
    bus2.JumpTarget   = 26'h0;
    bus2.Halt         = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_jump_priority();
    test_halt_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
